gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for one two-input logic gate.
// Sweeps {gate_a,gate_b} through 00,01,10,11. Each combination is held for
// SETTLE_CYCLES cycles and then sampled. The captured truth table is checked
// against a latched golden pattern.
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first
// mismatching sample instead of always sweeping all four combinations.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] truth_table,
    output logic [1:0] fail_idx
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TT_W  = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic              gate_a_q, gate_a_d;
    logic              gate_b_q, gate_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [TT_W-1:0]   tt_sample_c;
    logic [TT_W-1:0]   diff_c;
    logic [IDX_W-1:0]  first_diff_c;
    logic              stop_c;

    // Truth table including the current sample, its lowest mismatch, and whether this sample ends the sweep
    always_comb begin
        tt_sample_c        = tt_q;
        tt_sample_c[idx_q] = gate_y;
        diff_c             = tt_sample_c ^ exp_q;
        first_diff_c       = '0;
        for (int i = int'(TT_W) - 1; i >= 0; i--) begin
            if (diff_c[i]) begin
                first_diff_c = IDX_W'(i);
            end
        end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        stop_c = (idx_q == IDX_LAST) || diff_c[idx_q];
`else
        stop_c = (idx_q == IDX_LAST);
`endif
    end

    // Next-state and registered-output logic for the sweep sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        exp_d      = exp_q;
        tt_d       = tt_q;
        fail_idx_d = fail_idx_q;
        gate_a_d   = gate_a_q;
        gate_b_d   = gate_b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d      = expected;
                    idx_d      = '0;
                    gate_a_d   = 1'b0;
                    gate_b_d   = 1'b0;
                    tt_d       = '0;
                    pass_d     = 1'b0;
                    fail_idx_d = '0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                tt_d = tt_sample_c;
                if (stop_c) begin
                    pass_d     = (tt_sample_c == exp_q);
                    fail_idx_d = first_diff_c;
                    busy_d     = 1'b0;
                    gate_a_d   = 1'b0;
                    gate_b_d   = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    idx_d                = idx_q + IDX_W'(1);
                    {gate_a_d, gate_b_d} = idx_q + IDX_W'(1);
                    cnt_d                = '0;
                    state_d              = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            exp_q      <= '0;
            tt_q       <= '0;
            fail_idx_q <= '0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            exp_q      <= exp_d;
            tt_q       <= tt_d;
            fail_idx_q <= fail_idx_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign gate_a      = gate_a_q;
    assign gate_b      = gate_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign truth_table = tt_q;
    assign fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Testbench for gate_sweep_ctrl: two instances (SETTLE_CYCLES=2 and 1), each
// driving a table-lookup gate model. Table vectors, hand sequences for reset
// and start corner cases, and randomized sweeps checked against a reference model.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [3:0] expected;
    logic [3:0] gtbl;
    logic       glitch_en;
    logic       noise;
    logic       sel1;

    logic       a1, b1, busy1, done1, pass1, gy1;
    logic [3:0] tt1;
    logic [1:0] fi1;
    logic       a2, b2, busy2, done2, pass2, gy2;
    logic [3:0] tt2;
    logic [1:0] fi2;

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [3:0] o_tt;
    logic [1:0] o_fi;

    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    // Gate models: a truth-table lookup, optionally corrupted by noise
    assign gy2 = gtbl[{a2, b2}] ^ (glitch_en & noise);
    assign gy1 = gtbl[{a1, b1}] ^ (glitch_en & noise);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected), .gate_y(gy2),
        .gate_a(a2), .gate_b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .truth_table(tt2), .fail_idx(fi2)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected), .gate_y(gy1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .truth_table(tt1), .fail_idx(fi1)
    );

    assign o_a    = sel1 ? a1    : a2;
    assign o_b    = sel1 ? b1    : b2;
    assign o_busy = sel1 ? busy1 : busy2;
    assign o_done = sel1 ? done1 : done2;
    assign o_pass = sel1 ? pass1 : pass2;
    assign o_tt   = sel1 ? tt1   : tt2;
    assign o_fi   = sel1 ? fi1   : fi2;

    typedef struct {
        bit         pass;
        logic [3:0] tt;
        logic [1:0] fi;
        int         lat;
    } res_t;

    typedef struct {
        bit         s1;
        logic [3:0] e;
        logic [3:0] g;
        bit         gl;
        int         rep;
        bit         x_pass;
        logic [3:0] x_tt;
        logic [1:0] x_fi;
        int         x_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference result of one sweep of gate table g against golden e with settle time s
    function automatic res_t ref_model(input logic [3:0] e, input logic [3:0] g, input int s);
        res_t r;
        int   n;
        bit   stopped;
        bit   found;
        r.tt    = 4'b0000;
        n       = 4;
        stopped = 0;
        for (int i = 0; i < 4; i++) begin
            if (!stopped) begin
                r.tt[i] = g[i];
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                if (g[i] != e[i]) begin
                    stopped = 1;
                    n       = i + 1;
                end
`endif
            end
        end
        r.pass = (r.tt == e);
        r.fi   = 2'b00;
        found  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!found && r.tt[i] != e[i]) begin
                found = 1;
                r.fi  = 2'(i);
            end
        end
        r.lat = n * (s + 1);
        return r;
    endfunction

    // One sweep, starting at a negedge; ends at the negedge of the first IDLE cycle
    task automatic run_sweep(input string tag, input bit s1, input logic [3:0] e, input logic [3:0] g,
                             input bit gl, input int rep, input bit x_pass, input logic [3:0] x_tt,
                             input logic [1:0] x_fi, input int x_lat);
        int s;
        int k;
        int busy_cnt;
        bit seen;
        bit seq_ok;
        s         = s1 ? 1 : 2;
        sel1      = s1;
        gtbl      = g;
        glitch_en = gl;
        expected  = e;
        noise     = 1'b0;
        if (s1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1   = 1'b0;
        start2   = 1'b0;
        expected = ~e;
        k        = 0;
        seen     = 0;
        seq_ok   = 1;
        busy_cnt = 0;
        while (!seen && k < 80) begin
            noise = (k % (s + 1) != s) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (o_done) begin
                seen = 1;
            end else begin
                if (o_busy) busy_cnt++;
                if ({o_a, o_b} != 2'(k / (s + 1))) seq_ok = 0;
                if (k == 0) begin
                    check($sformatf("%s.clr_pass", tag), int'(o_pass), 0);
                    check($sformatf("%s.clr_tt", tag), int'(o_tt), 0);
                    check($sformatf("%s.clr_fi", tag), int'(o_fi), 0);
                end
                if (rep > 0 && k == rep - 1) begin
                    if (s1) start1 = 1'b1; else start2 = 1'b1;
                end
                @(posedge clk);
                #1;
                start1 = 1'b0;
                start2 = 1'b0;
                k++;
            end
        end
        if (!seen) begin
            check($sformatf("%s.done_timeout", tag), k, x_lat);
            glitch_en = 1'b0;
            @(negedge clk);
            return;
        end
        check($sformatf("%s.latency", tag), k, x_lat);
        check($sformatf("%s.pass", tag), int'(o_pass), int'(x_pass));
        check($sformatf("%s.truth_table", tag), int'(o_tt), int'(x_tt));
        check($sformatf("%s.fail_idx", tag), int'(o_fi), int'(x_fi));
        check($sformatf("%s.busy_at_done", tag), int'(o_busy), 0);
        check($sformatf("%s.ab_at_done", tag), int'({o_a, o_b}), 0);
        check($sformatf("%s.busy_cycles", tag), busy_cnt, x_lat);
        check($sformatf("%s.ab_sequence_ok", tag), int'(seq_ok), 1);
        @(posedge clk);
        #1;
        glitch_en = 1'b0;
        noise     = 1'b0;
        @(negedge clk);
        check($sformatf("%s.done_one_cycle", tag), int'(o_done), 0);
        check($sformatf("%s.pass_held", tag), int'(o_pass), int'(x_pass));
        check($sformatf("%s.tt_held", tag), int'(o_tt), int'(x_tt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start1    = 1'b0;
        start2    = 1'b0;
        expected  = 4'b0000;
        gtbl      = 4'b0000;
        glitch_en = 1'b0;
        noise     = 1'b0;
        sel1      = 1'b0;

        //            s1  e        g        gl rep  pass tt       fi     lat
        vecs[0] = '{1'b0, 4'b0111, 4'b0111, 1'b0, 5, 1'b1, 4'b0111, 2'd0, 12};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        vecs[1] = '{1'b0, 4'b0111, 4'b1000, 1'b0, 0, 1'b0, 4'b0000, 2'd0, 3};
`else
        vecs[1] = '{1'b0, 4'b0111, 4'b1000, 1'b0, 0, 1'b0, 4'b1000, 2'd0, 12};
`endif
        vecs[2] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 0, 1'b1, 4'b0111, 2'd0, 12};
        vecs[3] = '{1'b1, 4'b0111, 4'b0111, 1'b0, 0, 1'b1, 4'b0111, 2'd0, 8};
        vecs[4] = '{1'b0, 4'b0111, 4'b1111, 1'b0, 0, 1'b0, 4'b1111, 2'd3, 12};
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        vecs[5] = '{1'b1, 4'b0001, 4'b1110, 1'b0, 0, 1'b0, 4'b0000, 2'd0, 2};
        vecs[6] = '{1'b0, 4'b0111, 4'b0101, 1'b0, 0, 1'b0, 4'b0001, 2'd1, 6};
`else
        vecs[5] = '{1'b1, 4'b0001, 4'b1110, 1'b0, 0, 1'b0, 4'b1110, 2'd0, 8};
        vecs[6] = '{1'b0, 4'b0111, 4'b0101, 1'b0, 0, 1'b0, 4'b0101, 2'd1, 12};
`endif
        vecs[7] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 3, 1'b1, 4'b1000, 2'd0, 12};

        repeat (3) @(posedge clk);
        @(negedge clk);
        sel1 = 1'b0;
        #0;
        check("reset_dut2", int'({o_a, o_b, o_busy, o_done, o_pass, o_tt, o_fi}), 0);
        sel1 = 1'b1;
        #0;
        check("reset_dut1", int'({o_a, o_b, o_busy, o_done, o_pass, o_tt, o_fi}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven sweeps, back to back so each start lands in the first IDLE cycle
        for (int i = 0; i < 8; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].s1, vecs[i].e, vecs[i].g, vecs[i].gl,
                      vecs[i].rep, vecs[i].x_pass, vecs[i].x_tt, vecs[i].x_fi, vecs[i].x_lat);
        end

        // Reset asserted mid-sweep, sampled on edge E0+7
        sel1     = 1'b0;
        gtbl     = 4'b0111;
        expected = 4'b0111;
        start2   = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_midsweep", int'({o_a, o_b, o_busy, o_done, o_pass, o_tt, o_fi}), 0);
        // Reset and start together: no sweep begins
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_with_start_busy", int'(o_busy), 0);
        rst    = 1'b0;
        start2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("no_queued_start", int'(o_busy), 0);
        run_sweep("after_rst", 1'b0, 4'b0111, 4'b0111, 1'b0, 0, 1'b1, 4'b0111, 2'd0, 12);

        // Randomized sweeps against the reference model
        for (int r = 0; r < 30; r++) begin
            bit         rs1;
            bit         rgl;
            logic [3:0] re;
            logic [3:0] rg;
            int         rrep;
            res_t       m;
            re   = 4'($urandom);
            rg   = ($urandom_range(0, 1) == 1) ? re : 4'($urandom);
            rs1  = 1'($urandom);
            rgl  = 1'($urandom);
            rrep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
            m    = ref_model(re, rg, rs1 ? 1 : 2);
            run_sweep($sformatf("rnd%0d", r), rs1, re, rg, rgl, rrep, m.pass, m.tt, m.fi, m.lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
